// File: rtl/ldpc_iteration_sequencer.sv
// Phase controller for the flooding LDPC decoder: sweeps the C2R and R2C interleaver
// ROMs once per phase, drains the pipeline between phases and stops on parity or limit.
module ldpc_iteration_sequencer #(
   parameter int EXPANSION_FACTOR = 96,
   parameter int NUM_COLS         = 24,
   parameter int NUM_ROWS         = 12,
   parameter int DRAIN_CYCLES     = 4,
   parameter int ITER_W           = 6
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ITER_W-1:0] i_max_iter,
   input  logic              i_early_term_en,
   input  logic              i_parity_ok,
   input  logic              i_abort,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_valid_c2r,
   output logic              o_valid_r2c,
   output logic              o_first_iter,
   output logic [ITER_W-1:0] o_iteration,
   output logic              o_done,
   output logic              o_converged,
   output logic              o_aborted
);

   localparam int C2R_LEN  = NUM_COLS * EXPANSION_FACTOR;
   localparam int R2C_LEN  = NUM_ROWS * EXPANSION_FACTOR;
   localparam int PHASE_MAX = (C2R_LEN > R2C_LEN) ? C2R_LEN : R2C_LEN;
   localparam int CNT_W    = $clog2(PHASE_MAX);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_C2R       = 3'd1,
      S_C2R_DRAIN = 3'd2,
      S_R2C       = 3'd3,
      S_R2C_DRAIN = 3'd4,
      S_CHECK     = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ITER_W-1:0] iter_r, iter_s;
   logic [ITER_W-1:0] max_r, max_s;
   logic              et_r, et_s;
   logic              par_r, par_s;
   logic              first_r, first_s;
   logic              ready_r, ready_s;
   logic              busy_r, busy_s;
   logic              vc2r_r, vc2r_s;
   logic              vr2c_r, vr2c_s;
   logic              done_r, done_s;
   logic              conv_r, conv_s;
   logic              abt_r, abt_s;

   // Next-state and next-output logic; outputs trail the state by one cycle so each
   // phase state of length L produces exactly L valid cycles.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CNT_W'(1);
      iter_s  = iter_r;
      max_s   = max_r;
      et_s    = et_r;
      par_s   = par_r;
      first_s = first_r;
      ready_s = (state_r == S_IDLE);
      vc2r_s  = (state_r == S_C2R);
      vr2c_s  = (state_r == S_R2C);
      done_s  = (state_r == S_DONE);
      conv_s  = (state_r == S_DONE) ? par_r : 1'b0;
      abt_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            cnt_s = {CNT_W{1'b0}};
            if (ready_r && i_start) begin
               max_s   = (i_max_iter == {ITER_W{1'b0}}) ? ITER_W'(1) : i_max_iter;
               et_s    = i_early_term_en;
               par_s   = 1'b0;
               iter_s  = ITER_W'(1);
               first_s = 1'b1;
               ready_s = 1'b0;
               state_s = S_C2R;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_C2R: begin
            if (cnt_r == CNT_W'(C2R_LEN - 1)) begin
               state_s = S_C2R_DRAIN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = S_C2R;
            end
         end
         S_C2R_DRAIN: begin
            if (cnt_r == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_s = S_R2C;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = S_C2R_DRAIN;
            end
         end
         S_R2C: begin
            if (cnt_r == CNT_W'(R2C_LEN - 1)) begin
               state_s = S_R2C_DRAIN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = S_R2C;
            end
         end
         S_R2C_DRAIN: begin
            if (cnt_r == CNT_W'(DRAIN_CYCLES - 1)) begin
               state_s = S_CHECK;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = S_R2C_DRAIN;
            end
         end
         S_CHECK: begin
            par_s = i_parity_ok;
            cnt_s = {CNT_W{1'b0}};
            if ((et_r && i_parity_ok) || (iter_r == max_r)) begin
               state_s = S_DONE;
            end else begin
               iter_s  = iter_r + ITER_W'(1);
               first_s = 1'b0;
               state_s = S_C2R;
            end
         end
         S_DONE: begin
            cnt_s   = {CNT_W{1'b0}};
            first_s = 1'b0;
            state_s = S_IDLE;
         end
         default: begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = S_IDLE;
         end
      endcase
      // Abort overrides everything, including the CHECK decision.
      if (i_abort && (state_r != S_IDLE)) begin
         state_s = S_IDLE;
         cnt_s   = {CNT_W{1'b0}};
         first_s = 1'b0;
         vc2r_s  = 1'b0;
         vr2c_s  = 1'b0;
         done_s  = 1'b1;
         conv_s  = 1'b0;
         abt_s   = 1'b1;
         ready_s = 1'b0;
      end else begin
         abt_s = 1'b0;
      end
      busy_s = ~ready_s;
   end

   // State, configuration and output registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r <= S_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         iter_r  <= {ITER_W{1'b0}};
         max_r   <= {ITER_W{1'b0}};
         et_r    <= 1'b0;
         par_r   <= 1'b0;
         first_r <= 1'b0;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         vc2r_r  <= 1'b0;
         vr2c_r  <= 1'b0;
         done_r  <= 1'b0;
         conv_r  <= 1'b0;
         abt_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         iter_r  <= iter_s;
         max_r   <= max_s;
         et_r    <= et_s;
         par_r   <= par_s;
         first_r <= first_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         vc2r_r  <= vc2r_s;
         vr2c_r  <= vr2c_s;
         done_r  <= done_s;
         conv_r  <= conv_s;
         abt_r   <= abt_s;
      end
   end

   assign o_ready      = ready_r;
   assign o_busy       = busy_r;
   assign o_valid_c2r  = vc2r_r;
   assign o_valid_r2c  = vr2c_r;
   assign o_first_iter = first_r;
   assign o_iteration  = iter_r;
   assign o_done       = done_r;
   assign o_converged  = conv_r;
   assign o_aborted    = abt_r;

endmodule

// File: tb/tb_ldpc_iteration_sequencer.sv
// Directed bench for ldpc_iteration_sequencer at default parameters; cycle n is
// sampled 1 ns after the n-th clock edge following the start-accepting edge.
module tb_ldpc_iteration_sequencer;

   logic       i_clock = 1'b0;
   logic       i_reset;
   logic       i_start;
   logic [5:0] i_max_iter;
   logic       i_early_term_en;
   logic       i_parity_ok;
   logic       i_abort;
   logic       o_ready, o_busy, o_valid_c2r, o_valid_r2c, o_first_iter;
   logic [5:0] o_iteration;
   logic       o_done, o_converged, o_aborted;

   int n_cmp = 0;
   int n_bad = 0;

   // run statistics
   int c2r_cnt, r2c_cnt, c2r_first, c2r_last, r2c_first, r2c_last;
   int c2r_bursts, r2c_bursts, overlap, first_cnt, first_last;
   int done_cycle, done_count, ready_after, done_ready, done_r2c;
   int done_conv, done_abt, done_iter, ready_c1;
   int rs_ready, rs_busy, rs_iter, rs_valid, rs_done, rs_first;
   logic prev_c2r, prev_r2c;

   ldpc_iteration_sequencer dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
      .i_max_iter(i_max_iter), .i_early_term_en(i_early_term_en),
      .i_parity_ok(i_parity_ok), .i_abort(i_abort),
      .o_ready(o_ready), .o_busy(o_busy), .o_valid_c2r(o_valid_c2r),
      .o_valid_r2c(o_valid_r2c), .o_first_iter(o_first_iter),
      .o_iteration(o_iteration), .o_done(o_done), .o_converged(o_converged),
      .o_aborted(o_aborted)
   );

   always #5 i_clock = ~i_clock;

   task automatic run_decode(input logic [5:0] max_it, input logic et, input int par_lo,
                             input int par_hi, input int abort_at, input int start_at,
                             input int reset_at, input int budget);
      c2r_cnt = 0; r2c_cnt = 0; c2r_first = -1; c2r_last = -1; r2c_first = -1; r2c_last = -1;
      c2r_bursts = 0; r2c_bursts = 0; overlap = 0; first_cnt = 0; first_last = -1;
      done_cycle = -1; done_count = 0; ready_after = -1; done_ready = -1; done_r2c = -1;
      done_conv = -1; done_abt = -1; done_iter = -1; ready_c1 = -1;
      prev_c2r = 1'b0; prev_r2c = 1'b0;
      i_max_iter = max_it; i_early_term_en = et; i_start = 1'b1;
      @(posedge i_clock); #1;
      // configuration changes after the accepting edge must not matter
      i_start = 1'b0; i_max_iter = 6'd63; i_early_term_en = ~et;
      for (int n = 1; n <= budget; n++) begin
         @(posedge i_clock); #1;
         if (n == 1) ready_c1 = o_ready;
         if (o_valid_c2r) begin
            c2r_cnt++; c2r_last = n;
            if (c2r_first < 0) c2r_first = n;
            if (!prev_c2r) c2r_bursts++;
         end
         if (o_valid_r2c) begin
            r2c_cnt++; r2c_last = n;
            if (r2c_first < 0) r2c_first = n;
            if (!prev_r2c) r2c_bursts++;
         end
         if (o_valid_c2r && o_valid_r2c) overlap++;
         prev_c2r = o_valid_c2r; prev_r2c = o_valid_r2c;
         if (o_first_iter) begin first_cnt++; first_last = n; end
         if (o_done) begin
            done_count++;
            if (done_cycle < 0) begin
               done_cycle = n; done_conv = o_converged; done_abt = o_aborted;
               done_iter = o_iteration; done_ready = o_ready; done_r2c = o_valid_r2c;
            end
         end
         if (done_cycle > 0 && n == done_cycle + 1) begin
            ready_after = o_ready;
            break;
         end
         if (reset_at > 0 && n == reset_at + 1) begin
            rs_ready = o_ready; rs_busy = o_busy; rs_iter = o_iteration;
            rs_valid = o_valid_c2r | o_valid_r2c; rs_done = o_done; rs_first = o_first_iter;
            i_reset = 1'b0;
            break;
         end
         i_parity_ok = (n >= par_lo) && (n <= par_hi);
         i_abort     = (n == abort_at);
         i_reset     = (n == reset_at);
         i_start     = (n == start_at);
         if (n == start_at) i_max_iter = 6'd5;
      end
      i_parity_ok = 1'b0; i_abort = 1'b0; i_start = 1'b0; i_reset = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %0b want 1", o_ready); end
      n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", o_busy); end
      n_cmp++; if (o_iteration !== 6'd0) begin n_bad++; $display("FAIL reset_iter got %0d want 0", o_iteration); end
      n_cmp++; if ({o_valid_c2r, o_valid_r2c, o_first_iter, o_done, o_converged, o_aborted} !== 6'b0) begin
         n_bad++; $display("FAIL reset_flags got %b want 000000",
            {o_valid_c2r, o_valid_r2c, o_first_iter, o_done, o_converged, o_aborted});
      end
   endtask

   task automatic test_single_iter();
      run_decode(6'd1, 1'b0, 0, 0, 0, 0, 0, 4000);
      n_cmp++; if (ready_c1 !== 0) begin n_bad++; $display("FAIL single_ready_c1 got %0d want 0", ready_c1); end
      n_cmp++; if (c2r_cnt !== 2304 || c2r_first !== 1 || c2r_last !== 2304) begin
         n_bad++; $display("FAIL single_c2r got cnt=%0d %0d..%0d want 2304 1..2304", c2r_cnt, c2r_first, c2r_last); end
      n_cmp++; if (r2c_cnt !== 1152 || r2c_first !== 2309 || r2c_last !== 3460) begin
         n_bad++; $display("FAIL single_r2c got cnt=%0d %0d..%0d want 1152 2309..3460", r2c_cnt, r2c_first, r2c_last); end
      n_cmp++; if (done_cycle !== 3466 || done_conv !== 0 || done_iter !== 1 || done_abt !== 0) begin
         n_bad++; $display("FAIL single_done got cyc=%0d conv=%0d iter=%0d abt=%0d want 3466 0 1 0",
            done_cycle, done_conv, done_iter, done_abt); end
      n_cmp++; if (done_ready !== 0 || ready_after !== 1) begin
         n_bad++; $display("FAIL single_ready got %0d,%0d want 0,1", done_ready, ready_after); end
   endtask

   task automatic test_multi_iter();
      run_decode(6'd3, 1'b0, 0, 0, 0, 0, 0, 11000);
      n_cmp++; if (c2r_bursts !== 3 || c2r_cnt !== 6912 || r2c_bursts !== 3 || r2c_cnt !== 3456) begin
         n_bad++; $display("FAIL multi_bursts got c2r %0d/%0d r2c %0d/%0d want 3/6912 3/3456",
            c2r_bursts, c2r_cnt, r2c_bursts, r2c_cnt); end
      n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL multi_overlap got %0d want 0", overlap); end
      n_cmp++; if (first_cnt !== 3464 || first_last !== 3464) begin
         n_bad++; $display("FAIL multi_first got cnt=%0d last=%0d want 3464 3464", first_cnt, first_last); end
      n_cmp++; if (done_cycle !== 10396 || done_iter !== 3 || done_conv !== 0) begin
         n_bad++; $display("FAIL multi_done got cyc=%0d iter=%0d conv=%0d want 10396 3 0", done_cycle, done_iter, done_conv); end
   endtask

   task automatic test_early_term();
      // second CHECK is cycle 6929, sampled at edge 6930; window covers only that CHECK
      run_decode(6'd10, 1'b1, 6900, 6935, 0, 0, 0, 8000);
      n_cmp++; if (done_cycle !== 6931 || done_conv !== 1 || done_iter !== 2) begin
         n_bad++; $display("FAIL early_done got cyc=%0d conv=%0d iter=%0d want 6931 1 2", done_cycle, done_conv, done_iter); end
      run_decode(6'd10, 1'b0, 6900, 6935, 0, 0, 0, 36000);
      n_cmp++; if (done_cycle !== 34651 || done_conv !== 0 || done_iter !== 10) begin
         n_bad++; $display("FAIL noearly_done got cyc=%0d conv=%0d iter=%0d want 34651 0 10", done_cycle, done_conv, done_iter); end
   endtask

   task automatic test_abort();
      run_decode(6'd1, 1'b0, 0, 0, 3000, 0, 0, 4000);
      n_cmp++; if (done_cycle !== 3001 || done_abt !== 1 || done_conv !== 0 || done_r2c !== 0) begin
         n_bad++; $display("FAIL abort_done got cyc=%0d abt=%0d conv=%0d r2c=%0d want 3001 1 0 0",
            done_cycle, done_abt, done_conv, done_r2c); end
      n_cmp++; if (r2c_last !== 3000 || ready_after !== 1 || done_count !== 1) begin
         n_bad++; $display("FAIL abort_tail got r2c_last=%0d ready=%0d dones=%0d want 3000 1 1",
            r2c_last, ready_after, done_count); end
   endtask

   task automatic test_back_to_back();
      run_decode(6'd1, 1'b0, 0, 0, 0, 0, 0, 4000);
      n_cmp++; if (done_cycle !== 3466 || done_abt !== 0 || c2r_cnt !== 2304 || r2c_cnt !== 1152) begin
         n_bad++; $display("FAIL b2b got cyc=%0d abt=%0d c2r=%0d r2c=%0d want 3466 0 2304 1152",
            done_cycle, done_abt, c2r_cnt, r2c_cnt); end
   endtask

   task automatic test_start_while_busy();
      run_decode(6'd1, 1'b0, 0, 0, 0, 500, 0, 4000);
      n_cmp++; if (done_cycle !== 3466 || done_iter !== 1) begin
         n_bad++; $display("FAIL busy_start got cyc=%0d iter=%0d want 3466 1", done_cycle, done_iter); end
      run_decode(6'd0, 1'b0, 0, 0, 0, 0, 0, 4000);
      n_cmp++; if (done_cycle !== 3466 || done_iter !== 1 || c2r_bursts !== 1) begin
         n_bad++; $display("FAIL max_zero got cyc=%0d iter=%0d bursts=%0d want 3466 1 1", done_cycle, done_iter, c2r_bursts); end
   endtask

   task automatic test_reset_mid();
      int vcnt;
      int dcnt;
      run_decode(6'd1, 1'b0, 0, 0, 0, 0, 1000, 1100);
      n_cmp++; if (rs_ready !== 1 || rs_busy !== 0 || rs_iter !== 0 || rs_valid !== 0 || rs_first !== 0) begin
         n_bad++; $display("FAIL midreset_outs got rdy=%0d busy=%0d iter=%0d v=%0d first=%0d want 1 0 0 0 0",
            rs_ready, rs_busy, rs_iter, rs_valid, rs_first); end
      n_cmp++; if (rs_done !== 0 || done_count !== 0) begin
         n_bad++; $display("FAIL midreset_done got %0d/%0d want 0/0", rs_done, done_count); end
      vcnt = 0; dcnt = 0;
      for (int k = 0; k < 5000; k++) begin
         @(posedge i_clock); #1;
         if (o_valid_c2r || o_valid_r2c) vcnt++;
         if (o_done) dcnt++;
      end
      n_cmp++; if (vcnt !== 0 || dcnt !== 0) begin
         n_bad++; $display("FAIL midreset_idle got valids=%0d dones=%0d want 0 0", vcnt, dcnt); end
   endtask

   initial begin
      i_reset = 1'b1; i_start = 1'b0; i_max_iter = 6'd0; i_early_term_en = 1'b0;
      i_parity_ok = 1'b0; i_abort = 1'b0;
      repeat (3) @(posedge i_clock);
      #1;
      // start during reset must be overridden
      i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0; i_reset = 1'b0;
      @(posedge i_clock); #1;
      test_reset();
      test_single_iter();
      test_multi_iter();
      test_early_term();
      test_abort();
      test_back_to_back();
      test_start_while_busy();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ldpc_iteration_sequencer.md
Name: ldpc_iteration_sequencer

Overview:
- Top-level phase controller for the flooding LDPC decoder.
- Drives the valid/advance inputs of the column-to-row and row-to-column edge-interleaver ROMs, so that each ROM sweeps its full address space once per phase.
- Alternates C2R (variable-node) and R2C (check-node) phases, separated by pipeline drain gaps, for up to a programmed number of iterations.
- Terminates early on parity success and reports iteration count, convergence and abort status to the decoder wrapper.

Parameters:
- EXPANSION_FACTOR, 96, lifting size Z.
- NUM_COLS, 24, base-matrix columns; C2R phase length = NUM_COLS*Z cycles.
- NUM_ROWS, 12, base-matrix rows; R2C phase length = NUM_ROWS*Z cycles.
- DRAIN_CYCLES, 4, idle cycles after each phase for the datapath pipeline to flush (must be >=1).
- ITER_W, 6, width of the iteration count fields.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start request; accepted only when o_ready=1.
- i_max_iter  in  ITER_W  iteration limit, latched at start; 0 is treated as 1.
- i_early_term_en  in  1  enables early stop on parity; latched at start.
- i_parity_ok  in  1  syndrome-zero flag from the check datapath; sampled only in CHECK.
- i_abort  in  1  cancels the current decode.
- o_ready  out  1  high in IDLE.
- o_busy  out  1  high in any non-IDLE state.
- o_valid_c2r  out  1  drives the C2R ROM i_valid.
- o_valid_r2c  out  1  drives the R2C ROM i_valid.
- o_first_iter  out  1  high throughout iteration 1 (datapath selects channel LLRs only).
- o_iteration  out  ITER_W  current iteration, 1-based; holds its final value after done.
- o_done  out  1  one-cycle completion pulse.
- o_converged  out  1  valid with o_done; the parity result from the final CHECK.
- o_aborted  out  1  valid with o_done; high if the decode ended by i_abort.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_ready=1.
  - o_iteration=0.
  - All other outputs 0.
  - state=IDLE, counters=0.
- States: IDLE, C2R, C2R_DRAIN, R2C, R2C_DRAIN, CHECK, DONE.
- Cycle numbering: cycle n means n clocks after the edge that accepts i_start.
- IDLE:
  - On i_start=1: latch i_max_iter (0 becomes 1) and i_early_term_en.
  - Set o_iteration=1 and o_first_iter=1, then go to C2R.
- C2R:
  - o_valid_c2r=1 for exactly NUM_COLS*Z consecutive cycles (cycles 1..2304 at defaults).
  - Then go to C2R_DRAIN.
- C2R_DRAIN:
  - Both valids 0 for DRAIN_CYCLES cycles.
  - Then go to R2C.
- R2C:
  - o_valid_r2c=1 for exactly NUM_ROWS*Z cycles.
  - Then go to R2C_DRAIN (same length as C2R_DRAIN), then CHECK.
- CHECK (one cycle):
  - Sample i_parity_ok.
  - Stop if (early_term_en & parity_ok) or o_iteration==max_iter; go to DONE.
  - Otherwise increment o_iteration, clear o_first_iter, and go to C2R.
- DONE (one cycle):
  - o_done=1; o_converged=sampled parity_ok; o_aborted=0.
  - Next cycle: IDLE, o_ready=1.
- Iteration period at defaults: 2304+4+1152+4+1 = 3465 cycles.
- At most one valid is high in any cycle; valids are never high outside C2R/R2C.
- A single phase counter, width clog2(max(NUM_COLS,NUM_ROWS)*Z), is reused across phases and cleared on every state entry.
- i_start while busy: ignored, with no effect on the latched configuration.
- i_abort in any non-IDLE state:
  - Next cycle: both valids 0, o_done=1, o_aborted=1, o_converged=0.
  - Then IDLE.
  - i_abort in IDLE is ignored.
- Simultaneous events:
  - i_abort together with CHECK: abort wins.
  - i_start together with i_reset: reset wins.
- Reset mid-operation: on the next edge, all outputs and state return to reset values. There is no o_done pulse.
- Changes to i_parity_ok outside CHECK have no effect.

Test Plan:
- Single iteration, i_max_iter=1, i_parity_ok=0:
  - o_valid_c2r high cycles 1..2304.
  - o_valid_r2c high cycles 2309..3460.
  - o_done cycle 3466 with o_converged=0, o_iteration=1.
  - o_ready high cycle 3467.
- i_max_iter=3, parity never ok:
  - Exactly three C2R bursts of 2304 and three R2C bursts of 1152.
  - o_first_iter only during iteration 1.
  - o_done at cycle 10396, o_iteration=3.
- i_max_iter=10, early_term_en=1, i_parity_ok=1 only at the second CHECK (cycle 6930):
  - o_done at cycle 6931, o_converged=1, o_iteration=2.
  - Repeat with early_term_en=0: runs to iteration 10, o_done at cycle 34651.
- i_abort=1 at cycle 3000 (during R2C):
  - o_valid_r2c=0 and o_done=o_aborted=1 at cycle 3001.
  - o_ready=1 at cycle 3002.
  - A new start then runs a full iteration normally.
- i_start pulsed at cycle 500 with i_max_iter=5 during a 1-iteration decode:
  - Ignored; o_done at cycle 3466 with o_iteration=1.
  - i_max_iter=0 behaves identically to 1.
- i_reset asserted at cycle 1000 for one cycle:
  - Next cycle all outputs at reset values, no o_done.
  - Both valids stay 0 for 5000 idle cycles, the check counting any valid-high cycles must read 0.
